sync_fifo_flex: RTL and testbench

//  Single-clock FIFO: the parametrised successor to the dual-clock FIFO, for same-domain buffering.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_mem_dp.sv | 26 ++
 rtl/sync_fifo_flex.sv | 157 +++++++++++++++
 tb/tb_sync_fifo_flex.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  // Bit positions inside the bundled status vector
  localparam int FLAG_EMPTY  = 0;
  localparam int FLAG_AEMPTY = 1;
  localparam int FLAG_AFULL  = 2;
  localparam int FLAG_FULL   = 3;
  localparam int FLAG_OVF    = 4;
  localparam int FLAG_UNF    = 5;
  localparam int NUM_FLAGS   = 6;

  // Ceiling log2; clog2_fn(DEPTH+1) gives the width needed to hold 0..DEPTH
  function automatic int clog2_fn(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Storage array for sync_fifo_flex: synchronous write port, asynchronous read port.
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered reads.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = clog2_fn(DEPTH + 1);

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $fatal(1, "sync_fifo_flex: AFULL_THRESH out of range 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $fatal(1, "sync_fifo_flex: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rd_acc, wr_acc;
  logic [NUM_FLAGS-1:0]  status;

  fifo_mem_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

  // All flags come from the registered count, so they settle one cycle after an access
  assign status[FLAG_EMPTY]  = (count_q == '0);
  assign status[FLAG_AEMPTY] = (count_q <= AEMPTY_C);
  assign status[FLAG_AFULL]  = (count_q >= AFULL_C);
  assign status[FLAG_FULL]   = (count_q == DEPTH_C);
  assign status[FLAG_OVF]    = overflow_q;
  assign status[FLAG_UNF]    = underflow_q;

  assign empty        = status[FLAG_EMPTY];
  assign almost_empty = status[FLAG_AEMPTY];
  assign almost_full  = status[FLAG_AFULL];
  assign full         = status[FLAG_FULL];
  assign overflow     = status[FLAG_OVF];
  assign underflow    = status[FLAG_UNF];
  assign count        = count_q;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a write alongside it
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end
      count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
      overflow_d  = overflow_q | (wr_en & ~wr_acc);
      underflow_d = underflow_q | (rd_en & empty);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = mem_rdata;
  assign rd_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (!flush && rd_acc) begin
      rd_data_d  = mem_rdata;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex; works with and without SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_flex;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, rd_en;
  logic [7:0] wr_data;
  logic       full, almost_full, rd_valid, empty, almost_empty, overflow, underflow;
  logic [7:0] rd_data;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;

  sync_fifo_flex #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .AFULL_THRESH(6),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_data;
    logic [3:0] count;
    logic       empty, aempty, afull, full, ovf, unf;
  } vec_t;

  vec_t fill_tbl[9];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input int c, input bit e, input bit ae,
                            input bit af, input bit f, input bit ov, input bit un);
    chk({tag, ".count"},        32'(count), 32'(c));
    chk({tag, ".empty"},        32'(empty), 32'(e));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    chk({tag, ".almost_full"},  32'(almost_full), 32'(af));
    chk({tag, ".full"},         32'(full), 32'(f));
    chk({tag, ".overflow"},     32'(overflow), 32'(ov));
    chk({tag, ".underflow"},    32'(underflow), 32'(un));
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; rd_en = 1'b0; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  // Pop one word and check it; FWFT shows the word before the pop, standard mode after it
  task automatic pop_expect(input string tag, input logic [7:0] exp_d, input int exp_cnt);
    wr_en = 1'b0; rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, ".rd_data"},  32'(rd_data), 32'(exp_d));
`endif
    cyc();
    rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, ".rd_data"},  32'(rd_data), 32'(exp_d));
`endif
    chk({tag, ".count"}, 32'(count), 32'(exp_cnt));
    $display("pop  %s data=%02h expected=%02h count=%0d", tag, rd_data, exp_d, count);
  endtask

  task automatic chk_reset_state(input string tag);
    chk_status(tag, 0, 1, 1, 0, 0, 0, 0);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk({tag, ".rd_data"}, 32'(rd_data), 32'd0);
`endif
  endtask

  initial begin
    //              wr rd data   cnt  e  ae af f  ov un
    fill_tbl[0] = '{1, 0, 8'h10, 4'd1, 0, 1, 0, 0, 0, 0};
    fill_tbl[1] = '{1, 0, 8'h11, 4'd2, 0, 1, 0, 0, 0, 0};
    fill_tbl[2] = '{1, 0, 8'h12, 4'd3, 0, 0, 0, 0, 0, 0};
    fill_tbl[3] = '{1, 0, 8'h13, 4'd4, 0, 0, 0, 0, 0, 0};
    fill_tbl[4] = '{1, 0, 8'h14, 4'd5, 0, 0, 0, 0, 0, 0};
    fill_tbl[5] = '{1, 0, 8'h15, 4'd6, 0, 0, 1, 0, 0, 0};
    fill_tbl[6] = '{1, 0, 8'h16, 4'd7, 0, 0, 1, 0, 0, 0};
    fill_tbl[7] = '{1, 0, 8'h17, 4'd8, 0, 0, 1, 1, 0, 0};
    fill_tbl[8] = '{1, 0, 8'hFF, 4'd8, 0, 0, 1, 1, 1, 0};

    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    repeat (2) cyc();
    rst = 1'b0;
    chk_reset_state("reset");

    // Fill through all thresholds, then one rejected write
    for (int i = 0; i < 9; i++) begin
      wr_en = fill_tbl[i].wr_en; rd_en = fill_tbl[i].rd_en; wr_data = fill_tbl[i].wr_data;
      cyc();
      $display("fill vec%0d data=%02h count=%0d full=%0b ovf=%0b", i, fill_tbl[i].wr_data, count, full, overflow);
      chk_status($sformatf("fill%0d", i), int'(fill_tbl[i].count), fill_tbl[i].empty,
                 fill_tbl[i].aempty, fill_tbl[i].afull, fill_tbl[i].full,
                 fill_tbl[i].ovf, fill_tbl[i].unf);
    end
    wr_en = 1'b0;

    for (int i = 0; i < 8; i++) begin
      pop_expect($sformatf("drain%0d", i), 8'h10 + 8'(i), 7 - i);
    end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk_status("drain_under", 0, 1, 1, 0, 0, 1, 1);
    chk("drain_under.rd_valid", 32'(rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("drain_under.rd_data_hold", 32'(rd_data), 32'h17);
`endif

    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk_status("flush_clear", 0, 1, 1, 0, 0, 0, 0);

    // Simultaneous read and write while full
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    chk_status("full_pre", 8, 0, 0, 1, 1, 0, 0);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hAA;
`ifdef SYNC_FIFO_FWFT_EN
    chk("full_rw.rd_data_pre", 32'(rd_data), 32'h20);
`endif
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    $display("full_rw wr=AA count=%0d ovf=%0b", count, overflow);
    chk_status("full_rw", 8, 0, 0, 1, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("full_rw.rd_valid", 32'(rd_valid), 32'd1);
    chk("full_rw.rd_data", 32'(rd_data), 32'h20);
`endif
    for (int i = 0; i < 7; i++) pop_expect($sformatf("full_drain%0d", i), 8'h21 + 8'(i), 7 - i);
    pop_expect("full_drain_aa", 8'hAA, 0);

    // Interleaved traffic across two pointer wraps
    for (int i = 0; i < 20; i++) begin
      push(8'(i));
      chk($sformatf("wrap%0d.count_after_wr", i), 32'(count), 32'd1);
      pop_expect($sformatf("wrap%0d", i), 8'(i), 0);
    end

    // Write and read on empty: write accepted, read rejected
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    $display("empty_rw wr=5A count=%0d unf=%0b", count, underflow);
    chk_status("empty_rw", 1, 0, 1, 0, 0, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("empty_rw.rd_valid", 32'(rd_valid), 32'd0);
`endif
    pop_expect("empty_rw_pop", 8'h5A, 0);

    // Flush with pending write at count=5 and overflow set
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    push(8'hEE);
    for (int i = 0; i < 3; i++) pop_expect($sformatf("pre_flush%0d", i), 8'h30 + 8'(i), 7 - i);
    chk_status("pre_flush", 5, 0, 0, 0, 0, 1, 1);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    cyc();
    flush = 1'b0; wr_en = 1'b0;
    $display("flush wr=77 count=%0d ovf=%0b", count, overflow);
    chk_status("flush", 0, 1, 1, 0, 0, 0, 0);
    chk("flush.rd_valid", 32'(rd_valid), 32'd0);
    cyc();
    chk_status("flush_idle", 0, 1, 1, 0, 0, 0, 0);

    // Reset asserted for two cycles in the middle of traffic
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) push(8'h40 + 8'(i));
    chk_status("pre_rst", 3, 0, 0, 0, 0, 0, 1);
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
    repeat (2) cyc();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    $display("mid_reset count=%0d empty=%0b", count, empty);
    chk_reset_state("mid_reset");
    push(8'h99);
    pop_expect("post_reset", 8'h99, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
